// File: rtl/dpram_arb.sv
// Round-robin arbiter sharing one RAM port between two requesters, with bounded lock.
// Optional DPRAM_ARB_RDATA_HOLD_EN: per-requester read-data holding registers.
module dpram_arb #(
  parameter int unsigned AW       = 10,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_LOCK = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [3:0]    m0_wem,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_lock,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [3:0]    m1_wem,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_lock,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [3:0]    ram_wem,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam int unsigned LCW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  state_e         state_q;
  logic           rr_last_q;
  logic [LCW-1:0] lock_cnt_q;
  logic           m0_rvalid_q;
  logic           m1_rvalid_q;
  logic           gnt0_c;
  logic           gnt1_c;
  logic           lock_expire_c;

  // Grant: lock owner only while locked, otherwise round-robin on contention.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    case (state_q)
      LOCK0:   gnt0_c = m0_req;
      LOCK1:   gnt1_c = m1_req;
      default: begin
        if (m0_req && m1_req) begin
          gnt0_c = rr_last_q;
          gnt1_c = !rr_last_q;
        end else begin
          gnt0_c = m0_req;
          gnt1_c = m1_req;
        end
      end
    endcase
  end

  assign m0_gnt = gnt0_c;
  assign m1_gnt = gnt1_c;

  // RAM port mux; all-zero when nothing is granted.
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_wem  = 4'b0000;
    ram_addr = '0;
    ram_din  = '0;
    if (gnt0_c) begin
      ram_en   = 1'b1;
      ram_we   = m0_we;
      ram_wem  = m0_wem;
      ram_addr = m0_addr;
      ram_din  = m0_wdata;
    end else if (gnt1_c) begin
      ram_en   = 1'b1;
      ram_we   = m1_we;
      ram_wem  = m1_wem;
      ram_addr = m1_addr;
      ram_din  = m1_wdata;
    end
  end

  assign lock_expire_c = (lock_cnt_q == LCW'(MAX_LOCK - 1));

  // Arbitration state, lock bookkeeping and read-response strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_last_q   <= 1'b1;
      lock_cnt_q  <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
    end else begin
      m0_rvalid_q <= gnt0_c && !m0_we;
      m1_rvalid_q <= gnt1_c && !m1_we;
      if (gnt0_c) begin
        rr_last_q <= 1'b0;
      end else if (gnt1_c) begin
        rr_last_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          lock_cnt_q <= '0;
          if (gnt0_c && m0_lock) begin
            state_q <= LOCK0;
          end else if (gnt1_c && m1_lock) begin
            state_q <= LOCK1;
          end
        end
        LOCK0: begin
          lock_cnt_q <= lock_cnt_q + LCW'(1);
          if (lock_expire_c) begin
            state_q   <= IDLE;
            rr_last_q <= 1'b0;
          end else if (gnt0_c && !m0_lock) begin
            state_q <= IDLE;
          end
        end
        LOCK1: begin
          lock_cnt_q <= lock_cnt_q + LCW'(1);
          if (lock_expire_c) begin
            state_q   <= IDLE;
            rr_last_q <= 1'b1;
          end else if (gnt1_c && !m1_lock) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;

`ifdef DPRAM_ARB_RDATA_HOLD_EN
  logic [DW-1:0] m0_hold_q;
  logic [DW-1:0] m1_hold_q;

  // Capture each requester's response so it survives the other's reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_hold_q <= '0;
      m1_hold_q <= '0;
    end else begin
      if (m0_rvalid_q) m0_hold_q <= ram_dout;
      if (m1_rvalid_q) m1_hold_q <= ram_dout;
    end
  end

  assign m0_rdata = m0_rvalid_q ? ram_dout : m0_hold_q;
  assign m1_rdata = m1_rvalid_q ? ram_dout : m1_hold_q;
`else
  assign m0_rdata = ram_dout;
  assign m1_rdata = ram_dout;
`endif

endmodule

// File: tb/tb_dpram_arb.sv
// Self-checking bench for dpram_arb: vector table, directed corner cases, random vs. model.
module tb_dpram_arb;

  localparam int unsigned AW   = 10;
  localparam int unsigned DW   = 32;
  localparam int          MAXL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [3:0]    m0_wem, m1_wem;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          ram_en, ram_we;
  logic [3:0]    ram_wem;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dpram_arb #(.AW(AW), .DW(DW), .MAX_LOCK(MAXL)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_wem(m0_wem), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_lock(m0_lock), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_wem(m1_wem), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_lock(m1_lock), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_wem(ram_wem), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  function automatic logic [31:0] pattern(input int a);
    return 32'hC0DE0000 | 32'(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Byte-writable RAM with registered read, as seen on the shared port.
  logic [31:0] ram_mem [0:1023];
  logic        init_mem = 1'b0;
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 1024; i++) ram_mem[i] <= pattern(i);
    end else if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= merge(ram_mem[ram_addr], ram_din, ram_wem);
      else        ram_dout <= ram_mem[ram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, wanted %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drv0(input logic req, input logic we, input logic [3:0] wem,
                      input logic [AW-1:0] addr, input logic [DW-1:0] d, input logic lock);
    m0_req = req; m0_we = we; m0_wem = wem; m0_addr = addr; m0_wdata = d; m0_lock = lock;
  endtask

  task automatic drv1(input logic req, input logic we, input logic [3:0] wem,
                      input logic [AW-1:0] addr, input logic [DW-1:0] d, input logic lock);
    m1_req = req; m1_we = we; m1_wem = wem; m1_addr = addr; m1_wdata = d; m1_lock = lock;
  endtask

  task automatic idle_all();
    drv0(1'b0, 1'b0, 4'h0, '0, '0, 1'b0);
    drv1(1'b0, 1'b0, 4'h0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_all();
    #1;
    chk("rst_rvalid0", 32'(m0_rvalid), 32'd0);
    chk("rst_rvalid1", 32'(m1_rvalid), 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit r0, l0, r1, l1;
    bit g0, g1, rv0, rv1;
  } vec_t;
  vec_t tbl [17];

  task automatic set_row(input int i, input bit r0, input bit l0, input bit r1, input bit l1,
                         input bit g0, input bit g1, input bit rv0, input bit rv1);
    tbl[i].r0 = r0; tbl[i].l0 = l0; tbl[i].r1 = r1; tbl[i].l1 = l1;
    tbl[i].g0 = g0; tbl[i].g1 = g1; tbl[i].rv0 = rv0; tbl[i].rv1 = rv1;
  endtask

  // Reference model state: lock owner (-1 none), cycles spent locked, last winner.
  int          m_owner;
  int          m_age;
  bit          m_last;
  bit          exp_rv0, exp_rv1;
  logic [31:0] exp_d0, exp_d1;
  logic [31:0] refmem [0:1023];

  initial begin
    idle_all();
    @(negedge clk);
    init_mem = 1'b1;
    @(negedge clk);
    init_mem = 1'b0;

    // All reads; m0 uses addr i, m1 uses addr 100+i.
    set_row( 0, 1,0,1,0, 1,0,0,0);
    set_row( 1, 1,0,1,0, 0,1,1,0);
    set_row( 2, 1,0,1,0, 1,0,0,1);
    set_row( 3, 1,0,1,0, 0,1,1,0);
    set_row( 4, 1,0,1,0, 1,0,0,1);
    set_row( 5, 1,0,1,0, 0,1,1,0);
    set_row( 6, 1,0,1,0, 1,0,0,1);
    set_row( 7, 1,0,1,1, 0,1,1,0);
    set_row( 8, 1,0,1,1, 0,1,0,1);
    set_row( 9, 1,0,1,0, 0,1,0,1);
    set_row(10, 1,0,1,0, 1,0,0,1);
    set_row(11, 0,0,0,0, 0,0,1,0);
    set_row(12, 0,0,1,0, 0,1,0,0);
    set_row(13, 0,0,1,1, 0,1,0,1);
    set_row(14, 1,0,0,0, 0,0,0,1);
    set_row(15, 1,0,1,0, 0,1,0,0);
    set_row(16, 1,0,0,0, 1,0,0,1);

    do_reset();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drv0(tbl[i].r0, 1'b0, 4'h0, AW'(i), '0, tbl[i].l0);
      drv1(tbl[i].r1, 1'b0, 4'h0, AW'(100 + i), '0, tbl[i].l1);
      #1;
      chk($sformatf("tbl%0d_gnt0", i), 32'(m0_gnt), 32'(tbl[i].g0));
      chk($sformatf("tbl%0d_gnt1", i), 32'(m1_gnt), 32'(tbl[i].g1));
      chk($sformatf("tbl%0d_ram_en", i), 32'(ram_en), 32'(tbl[i].g0 | tbl[i].g1));
      chk($sformatf("tbl%0d_rvalid0", i), 32'(m0_rvalid), 32'(tbl[i].rv0));
      chk($sformatf("tbl%0d_rvalid1", i), 32'(m1_rvalid), 32'(tbl[i].rv1));
      if (tbl[i].rv0) chk($sformatf("tbl%0d_rdata0", i), m0_rdata, pattern(i - 1));
      if (tbl[i].rv1) chk($sformatf("tbl%0d_rdata1", i), m1_rdata, pattern(100 + i - 1));
    end

    // Single write then read through m0.
    do_reset();
    @(negedge clk);
    drv0(1'b1, 1'b1, 4'hF, 10'h005, 32'hDEADBEEF, 1'b0);
    #1;
    chk("wr_gnt0", 32'(m0_gnt), 32'd1);
    chk("wr_ram_we", 32'(ram_we), 32'd1);
    chk("wr_ram_din", ram_din, 32'hDEADBEEF);
    @(negedge clk);
    drv0(1'b1, 1'b0, 4'h0, 10'h005, '0, 1'b0);
    #1;
    chk("wr_no_rvalid", 32'(m0_rvalid), 32'd0);
    chk("rd_gnt0", 32'(m0_gnt), 32'd1);
    chk("rd_ram_addr", 32'(ram_addr), 32'h005);
    @(negedge clk);
    idle_all();
    #1;
    chk("rd_rvalid0", 32'(m0_rvalid), 32'd1);
    chk("rd_rdata0", m0_rdata, 32'hDEADBEEF);
    chk("rd_rvalid1", 32'(m1_rvalid), 32'd0);

    // Byte-enable merge and zero-enable write through m1.
    @(negedge clk);
    drv1(1'b1, 1'b1, 4'hF, 10'h3FF, 32'hAABBCCDD, 1'b0);
    @(negedge clk);
    drv1(1'b1, 1'b1, 4'b0101, 10'h3FF, 32'h11223344, 1'b0);
    @(negedge clk);
    drv1(1'b1, 1'b0, 4'h0, 10'h3FF, '0, 1'b0);
    @(negedge clk);
    drv1(1'b1, 1'b1, 4'h0, 10'h3FF, 32'hFFFFFFFF, 1'b0);
    #1;
    chk("be_rvalid1", 32'(m1_rvalid), 32'd1);
    chk("be_rdata1", m1_rdata, 32'hAA22CC44);
    chk("wem0_ram_en", 32'(ram_en), 32'd1);
    chk("wem0_ram_wem", 32'(ram_wem), 32'd0);
    @(negedge clk);
    drv1(1'b1, 1'b0, 4'h0, 10'h3FF, '0, 1'b0);
    @(negedge clk);
    idle_all();
    #1;
    chk("wem0_rvalid1", 32'(m1_rvalid), 32'd1);
    chk("wem0_rdata1", m1_rdata, 32'hAA22CC44);
    chk("wem0_rvalid0", 32'(m0_rvalid), 32'd0);

    // m0 holds lock with m1 waiting: forced release after MAXL locked cycles.
    do_reset();
    for (int k = 0; k <= MAXL + 1; k++) begin
      @(negedge clk);
      drv0(1'b1, 1'b0, 4'h0, AW'(k), '0, 1'b1);
      drv1(1'b1, 1'b0, 4'h0, AW'(k), '0, 1'b0);
      #1;
      chk($sformatf("lto%0d_gnt0", k), 32'(m0_gnt), 32'(k <= MAXL));
      chk($sformatf("lto%0d_gnt1", k), 32'(m1_gnt), 32'(k == MAXL + 1));
    end

    // Reset in the cycle after a locked read is accepted.
    do_reset();
    @(negedge clk);
    drv0(1'b1, 1'b0, 4'h0, 10'h010, '0, 1'b1);
    @(posedge clk);
    #1;
    chk("mid_pre_rvalid0", 32'(m0_rvalid), 32'd1);
    idle_all();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid0", 32'(m0_rvalid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drv1(1'b1, 1'b0, 4'h0, 10'h011, '0, 1'b0);
    #1;
    chk("mid_unlocked_gnt1", 32'(m1_gnt), 32'd1);
    do_reset();
    @(negedge clk);
    drv0(1'b1, 1'b0, 4'h0, 10'h012, '0, 1'b0);
    drv1(1'b1, 1'b0, 4'h0, 10'h013, '0, 1'b0);
    #1;
    chk("mid_first_gnt0", 32'(m0_gnt), 32'd1);
    chk("mid_first_gnt1", 32'(m1_gnt), 32'd0);

    // Random traffic against the reference model.
    do_reset();
    for (int i = 0; i < 1024; i++) refmem[i] = ram_mem[i];
    m_owner = -1; m_age = 0; m_last = 1'b1; exp_rv0 = 1'b0; exp_rv1 = 1'b0;
    exp_d0 = '0; exp_d1 = '0;
    for (int c = 0; c < 3000; c++) begin
      logic r0, w0, l0, r1, w1, l1, g0, g1;
      logic [3:0] e0, e1;
      logic [AW-1:0] a0, a1;
      logic [DW-1:0] d0, d1;
      int acc;
      @(negedge clk);
      r0 = ($urandom_range(0, 3) != 0); w0 = 1'($urandom); l0 = 1'($urandom);
      r1 = ($urandom_range(0, 3) != 0); w1 = 1'($urandom); l1 = 1'($urandom);
      e0 = 4'($urandom); e1 = 4'($urandom);
      a0 = AW'($urandom_range(0, 15)); a1 = AW'($urandom_range(0, 15));
      d0 = $urandom; d1 = $urandom;
      drv0(r0, w0, e0, a0, d0, l0);
      drv1(r1, w1, e1, a1, d1, l1);
      #1;
      g0 = 1'b0; g1 = 1'b0;
      if (m_owner == 0) g0 = r0;
      else if (m_owner == 1) g1 = r1;
      else if (r0 && r1) begin
        if (m_last) g0 = 1'b1; else g1 = 1'b1;
      end else begin
        g0 = r0; g1 = r1;
      end
      chk("rnd_gnt0", 32'(m0_gnt), 32'(g0));
      chk("rnd_gnt1", 32'(m1_gnt), 32'(g1));
      chk("rnd_ram_en", 32'(ram_en), 32'(g0 | g1));
      chk("rnd_ram_addr", 32'(ram_addr), g0 ? 32'(a0) : (g1 ? 32'(a1) : 32'd0));
      chk("rnd_ram_din", ram_din, g0 ? d0 : (g1 ? d1 : 32'd0));
      chk("rnd_ram_we", 32'({ram_we, ram_wem}),
          g0 ? 32'({w0, e0}) : (g1 ? 32'({w1, e1}) : 32'd0));
      chk("rnd_rvalid0", 32'(m0_rvalid), 32'(exp_rv0));
      chk("rnd_rvalid1", 32'(m1_rvalid), 32'(exp_rv1));
      if (exp_rv0) chk("rnd_rdata0", m0_rdata, exp_d0);
      if (exp_rv1) chk("rnd_rdata1", m1_rdata, exp_d1);

      acc = g0 ? 0 : (g1 ? 1 : -1);
      exp_rv0 = (acc == 0) && !w0;
      exp_rv1 = (acc == 1) && !w1;
      if (acc == 0) begin
        if (w0) refmem[a0] = merge(refmem[a0], d0, e0); else exp_d0 = refmem[a0];
      end else if (acc == 1) begin
        if (w1) refmem[a1] = merge(refmem[a1], d1, e1); else exp_d1 = refmem[a1];
      end
      if (acc >= 0) m_last = (acc == 1);
      if (m_owner >= 0) begin
        m_age++;
        if (m_age >= MAXL) begin
          m_last  = (m_owner == 1);
          m_owner = -1;
        end else if (acc == m_owner && !(acc == 0 ? l0 : l1)) begin
          m_owner = -1;
        end
      end else if (acc == 0 && l0) begin
        m_owner = 0; m_age = 0;
      end else if (acc == 1 && l1) begin
        m_owner = 1; m_age = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dpram_arb.md
Name: dpram_arb

Overview:
- Two-requester arbiter that shares one port of the core's byte-writable dual-port RAM, for example port B shared between the debug module and the data bus.
- Each requester gets a req/gnt handshake and a read-response strobe that accounts for the RAM's 1-cycle registered read.
- Round-robin fairness, plus an optional bounded lock so one requester can issue back-to-back sequences without interleaving.

Parameters:
- AW, 10, RAM word-address width; matches a 1024-entry RAM.
- DW, 32, data width; fixed at 32 because byte-enables are 4 bits.
- MAX_LOCK, 16, maximum cycles one requester may hold a lock; must be ≥1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- m0_req  in  1  requester 0 transfer request
- m0_we  in  1  1 = write, 0 = read
- m0_wem  in  4  byte write enables
- m0_addr  in  AW  word address
- m0_wdata  in  DW  write data
- m0_lock  in  1  keep grant after this transfer
- m0_gnt  out  1  request accepted this cycle (combinational)
- m0_rvalid  out  1  read data valid
- m0_rdata  out  DW  read data
- m1_*  same set as m0_*, for requester 1
- ram_en  out  1  RAM port enable
- ram_we  out  1  RAM port write
- ram_wem  out  4  RAM byte enables
- ram_addr  out  AW  RAM address
- ram_din  out  DW  RAM write data
- ram_dout  in  DW  RAM read data, valid 1 cycle after a read enable

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Reset values: state=IDLE, rr_last=1 (m0 wins first contention), lock_cnt=0, m0_rvalid=m1_rvalid=0, rdata holding registers (if present) = 0.
- Transfer acceptance: a transfer is accepted when mN_req && mN_gnt in the same cycle.
  - gnt is combinational from req, state and rr_last.
  - At most one gnt is high per cycle.
  - mN_gnt=0 whenever mN_req=0.
- RAM drive (combinational):
  - ram_en=1 only in a cycle with an accepted transfer.
  - ram_we/wem/addr/din are muxed from the granted requester.
  - With no grant: ram_en=0 and all other RAM outputs 0.
- State IDLE:
  - One requester active: grant it.
  - Both active: grant the requester ≠ rr_last.
  - rr_last updates to the granted index on every accepted transfer.
- State LOCK0 / LOCK1:
  - Entered from IDLE, or re-entered, when an accepted transfer from N has mN_lock=1.
  - In LOCKn only mN can be granted; the other requester's gnt=0 even if mN_req=0.
  - lock_cnt increments every cycle in a LOCK state and clears on entry.
  - Exit to IDLE on either of:
    - an accepted mN transfer with mN_lock=0;
    - lock_cnt==MAX_LOCK-1, which forces release. On forced release, rr_last=n, so the other requester wins the next contention.
  - The transfer accepted in the release cycle still completes normally.
- Read response:
  - mN_rvalid is a registered copy of (accept from N && !mN_we), so it is high exactly 1 cycle after acceptance.
  - mN_rdata = ram_dout.
  - Back-to-back reads produce back-to-back rvalid pulses with no bubble; throughput is 1 transfer/cycle.
- Writes:
  - Writes produce no rvalid.
  - wem=4'b0000 is accepted and forwarded; the RAM contents do not change.
- Boundaries:
  - Simultaneous req from both requesters every cycle: grants strictly alternate.
  - Reset asserted mid-operation: any pending rvalid is dropped and the lock is released.
  - Address and data pass through unmodified; no wrap or range checks.

Optional Feature:
- Macro: DPRAM_ARB_RDATA_HOLD_EN.
- Defined:
  - Each requester has its own DW-bit register, loaded from ram_dout in the cycle its rvalid=1.
  - mN_rdata = rvalid ? ram_dout : held register, so mN_rdata stays stable until that requester's next read response, unaffected by the other requester's reads.
- Undefined:
  - mN_rdata = ram_dout directly.
  - Data is guaranteed only while mN_rvalid=1.

Test Plan:
- Single read: write 0xDEADBEEF to addr 0x005 via m0 with wem=4'hF, then m0 reads 0x005 → m0_gnt same cycle, m0_rvalid 1 cycle later, m0_rdata=0xDEADBEEF, m1_rvalid stays 0.
- Byte writes: m1 writes 0x11223344 to 0x3FF with wem=4'b0101, over prior content 0xAABBCCDD → read returns 0xAA22CC44; a write with wem=0 leaves it unchanged.
- Contention: both req held for 6 cycles after reset → grant sequence m0,m1,m0,m1,m0,m1; each read gets its rvalid exactly 1 cycle after its grant.
- Lock: m1 issues 3 reads with lock=1,1,0 while m0 is requesting throughout → m0_gnt=0 for those 3 cycles, then m0 is granted the next cycle.
- Lock timeout: m0 holds lock=1 with MAX_LOCK=4 → forced release after 4 cycles in LOCK0; m1 is granted the next cycle.
- Reset mid-read: assert rst_n=0 in the cycle after a read is accepted → rvalid=0 immediately; after release, state is IDLE and m0 wins the first contention.
